// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg
//   Shared constants for the load/store unit: access size encodings, fault
//   cause codes, FSM state encodings and byte-enable patterns, plus the
//   alignment check used when an access is accepted.
package core_lsu_pkg;

  // Access size encodings (size_i); 2'b11 is reserved and behaves as word
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Fault cause codes (fault_cause_o)
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Byte-enable patterns
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Half needs an even address, word (and reserved) needs a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align
//   Combinational lane logic for a 32-bit data bus.
//   Ports:
//     size_i      access size encoding
//     addr_lo_i   byte offset within the word (addr[1:0])
//     unsign_i    zero-extend loads when set
//     st_data_i   right-justified store data
//     ld_word_i   raw bus read word
//     be_o        byte enables for the access
//     st_lanes_o  store data replicated into every lane it may occupy
//     ld_data_o   load data shifted down and sign/zero extended
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsign_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_lanes_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] w_shifted;

  // Move the addressed byte/half down to bit 0
  assign w_shifted = ld_word_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o       = BE_WORD;
    st_lanes_o = st_data_i;
    ld_data_o  = w_shifted;
    case (size_i)
      SIZE_BYTE: begin
        be_o       = 4'b0001 << addr_lo_i;
        st_lanes_o = {4{st_data_i[7:0]}};
        ld_data_o  = unsign_i ? {24'h0, w_shifted[7:0]}
                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        be_o       = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        st_lanes_o = {2{st_data_i[15:0]}};
        ld_data_o  = unsign_i ? {16'h0, w_shifted[15:0]}
                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        // word and reserved encoding: full lanes, no extension
        be_o       = BE_WORD;
        st_lanes_o = st_data_i;
        ld_data_o  = w_shifted;
      end
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// core_lsu
//   Load/store unit behind the execute stage. Accepts one memory operation
//   at a time, runs a single-outstanding req/ack bus access, and returns a
//   one-cycle register write-back or a one-cycle fault pulse.
//   Ports:
//     clk_i, rst_i                      clock, async active-high reset
//     mem_en_i/we_i/size_i/unsign_i     operation from execute
//     addr_i/wdata_i/reg_waddr_i        effective address, store data, rd
//     hold_o                            pipeline stall request
//     mem_req_o/we/addr/be/wdata        bus request side (held until ack)
//     mem_ack_i/mem_rdata_i             bus completion and read data
//     reg_we_o/reg_waddr_o/reg_wdata_o  write-back strobe and payload
//     fault_o/fault_cause_o/fault_addr_o fault pulse and details
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_en_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsign_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  reg_waddr_i,
  output logic              hold_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              reg_we_o,
  output logic [REG_W-1:0]  reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              fault_o,
  output logic [1:0]        fault_cause_o,
  output logic [DATA_W-1:0] fault_addr_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsign;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [REG_W-1:0]  r_waddr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;
  logic [1:0]        r_cause;

  logic              w_in_req;
  logic              w_in_done;
  logic [3:0]        w_be;
  logic [31:0]       w_lanes;
  logic [31:0]       w_ld_data;

  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_done = (r_state == ST_DONE);

  core_lsu_align u_align (
    .size_i     (r_size),
    .addr_lo_i  (r_addr[1:0]),
    .unsign_i   (r_unsign),
    .st_data_i  (r_wdata),
    .ld_word_i  (r_rdata),
    .be_o       (w_be),
    .st_lanes_o (w_lanes),
    .ld_data_o  (w_ld_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_unsign <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_waddr  <= '0;
      r_rdata  <= '0;
      r_fault  <= 1'b0;
      r_cause  <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_en_i) begin
            r_we     <= we_i;
            r_size   <= size_i;
            r_unsign <= unsign_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_waddr  <= reg_waddr_i;
            r_cnt    <= '0;
            if (is_misaligned(size_i, addr_i[1:0])) begin
              r_fault <= 1'b1;
              r_cause <= CAUSE_MISALIGN;
              r_state <= ST_DONE;
            end else begin
              r_fault <= 1'b0;
              r_cause <= CAUSE_NONE;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Ack takes priority over a timeout in the same cycle
          if (mem_ack_i) begin
            r_rdata <= mem_rdata_i;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
            r_state <= ST_DONE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus side is driven only while the request is outstanding
  assign mem_req_o   = w_in_req;
  assign mem_we_o    = w_in_req & r_we;
  assign mem_addr_o  = w_in_req ? {r_addr[DATA_W-1:2], 2'b00} : '0;
  assign mem_be_o    = w_in_req ? w_be : 4'b0000;
  assign mem_wdata_o = w_in_req ? DATA_W'(w_lanes) : '0;

  // Stall covers the accept cycle (combinational on mem_en_i) and the wait
  assign hold_o = ((r_state == ST_IDLE) & mem_en_i) | w_in_req;

  // Write-back only for a successful load to a non-zero register
  assign reg_we_o    = w_in_done & ~r_fault & ~r_we & (r_waddr != '0);
  assign reg_waddr_o = reg_we_o ? r_waddr : '0;
  assign reg_wdata_o = reg_we_o ? DATA_W'(w_ld_data) : '0;

  assign fault_o       = w_in_done & r_fault;
  assign fault_cause_o = fault_o ? r_cause : CAUSE_NONE;
  assign fault_addr_o  = fault_o ? r_addr : '0;

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rd = '0;
  logic        hold;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_req;

  always #5 clk = ~clk;

  core_lsu #(.DATA_W(32), .REG_W(5), .TIMEOUT(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_en_i      (mem_en),
    .we_i          (we),
    .size_i        (size),
    .unsign_i      (unsign),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .reg_waddr_i   (rd),
    .hold_o        (hold),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_be_o      (mem_be),
    .mem_wdata_o   (mem_wdata),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .reg_we_o      (reg_we),
    .reg_waddr_o   (reg_waddr),
    .reg_wdata_o   (reg_wdata),
    .fault_o       (fault),
    .fault_cause_o (fault_cause),
    .fault_addr_o  (fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for exactly one cycle (the accept cycle)
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    mem_en = 1'b1; we = w; size = sz; unsign = u; addr = a; wdata = d; rd = r;
    #1;
    chk("hold_accept", 32'(hold), 32'd1);
    chk("req_accept", 32'(mem_req), 32'd0);
    tick();
    mem_en = 1'b0;
  endtask

  // Load with ack in the first REQ cycle; returns write-back data check
  task automatic load1(input string tag, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] rdw, input logic [4:0] r,
                       input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(1'b0, sz, u, a, 32'h0, r);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, "_mwe"}, 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = rdw;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk({tag, "_regwe"}, 32'(reg_we), (r != 0) ? 32'd1 : 32'd0);
    if (r != 0) begin
      chk({tag, "_wdata"}, reg_wdata, exp_data);
      chk({tag, "_waddr"}, 32'(reg_waddr), 32'(r));
    end
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_hold_done"}, 32'(hold), 32'd0);
    tick();
    chk({tag, "_regwe_idle"}, 32'(reg_we), 32'd0);
    $display("[TB] %s addr=0x%08h rdata=0x%08h -> 0x%08h", tag, a, rdw, reg_wdata);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_regwe", 32'(reg_we), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    load1("LW", 2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 5'd3, 4'b1111, 32'hDEAD_BEEF);
    load1("LB_s", 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_FF00, 5'd4, 4'b1000, 32'hFFFF_FF80);
    load1("LBU", 2'b00, 1'b1, 32'h0000_1003, 32'h80FF_FF00, 5'd4, 4'b1000, 32'h0000_0080);
    load1("LH_s", 2'b01, 1'b0, 32'h0000_1002, 32'h9234_5678, 5'd5, 4'b1100, 32'hFFFF_9234);
    load1("LHU", 2'b01, 1'b1, 32'h0000_1000, 32'h1234_8765, 5'd6, 4'b0011, 32'h0000_8765);
    load1("LB1", 2'b00, 1'b0, 32'h0000_1001, 32'h0000_7F00, 5'd7, 4'b0010, 32'h0000_007F);
    load1("LW_x0", 2'b10, 1'b0, 32'h0000_1004, 32'h1111_2222, 5'd0, 4'b1111, 32'h0);

    // SH 0x1234 at 0x2002
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_1234, 5'd9);
    chk("SH_be", 32'(mem_be), 32'b1100);
    chk("SH_wdata", mem_wdata, 32'h1234_1234);
    chk("SH_mwe", 32'(mem_we), 32'd1);
    chk("SH_addr", mem_addr, 32'h0000_2000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("SH_regwe", 32'(reg_we), 32'd0);
    chk("SH_fault", 32'(fault), 32'd0);
    tick();
    $display("[TB] SH addr=0x00002002 data=0x1234 done");

    // SB replication
    issue(1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5, 5'd0);
    chk("SB_be", 32'(mem_be), 32'b0010);
    chk("SB_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    $display("[TB] SB addr=0x00002001 data=0xA5 done");

    // Misaligned LW at 0x2001
    issue(1'b0, 2'b10, 1'b0, 32'h0000_2001, 32'h0, 5'd8);
    chk("MIS_fault", 32'(fault), 32'd1);
    chk("MIS_cause", 32'(fault_cause), 32'd1);
    chk("MIS_addr", fault_addr, 32'h0000_2001);
    chk("MIS_req", 32'(mem_req), 32'd0);
    chk("MIS_hold", 32'(hold), 32'd0);
    chk("MIS_regwe", 32'(reg_we), 32'd0);
    tick();
    chk("MIS_fault_idle", 32'(fault), 32'd0);
    $display("[TB] LW misaligned addr=0x00002001 faulted");

    // Timeout: no ack, req must stay high exactly 4 cycles
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 5'd2);
    n_req = 0;
    while (mem_req && n_req < 10) begin
      n_req++;
      tick();
    end
    chk("TO_req_cycles", 32'(n_req), 32'd4);
    chk("TO_fault", 32'(fault), 32'd1);
    chk("TO_cause", 32'(fault_cause), 32'd2);
    chk("TO_regwe", 32'(reg_we), 32'd0);
    tick();
    $display("[TB] LW timeout addr=0x00003000 req_cycles=%0d", n_req);

    // Ack on the 4th REQ cycle wins over the timeout
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0, 5'd2);
    tick(); tick(); tick();
    chk("TOA_req4", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("TOA_fault", 32'(fault), 32'd0);
    chk("TOA_regwe", 32'(reg_we), 32'd1);
    chk("TOA_wdata", reg_wdata, 32'hCAFE_F00D);
    tick();
    $display("[TB] LW ack on last cycle addr=0x00003004 completed");

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("IDLEACK_regwe", 32'(reg_we), 32'd0);
    chk("IDLEACK_req", 32'(mem_req), 32'd0);
    tick();
    chk("IDLEACK_regwe2", 32'(reg_we), 32'd0);
    $display("[TB] stray ack in IDLE ignored");

    // Reset while in REQ
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd1);
    chk("RST_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("RST_req_async", 32'(mem_req), 32'd0);
    chk("RST_hold_async", 32'(hold), 32'd0);
    tick();
    chk("RST_regwe", 32'(reg_we), 32'd0);
    chk("RST_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    tick();
    $display("[TB] reset during REQ dropped request");
    load1("LW_after_rst", 2'b10, 1'b0, 32'h0000_4000, 32'h0BAD_CAFE, 5'd1, 4'b1111, 32'h0BAD_CAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit sitting directly downstream of the execute stage. It captures a memory operation when execute asserts its memory enable, with the effective address taken from the execute result. It drives a single-outstanding req/ack data bus, aligns and extends load data, and returns a one-cycle register write-back. The pipeline is stalled from acceptance until the access completes or faults.

## Interface
- DATA_W, 32: data/address width (matches `DATA_BUS_WIDTH`)
- REG_W, 5: register address width (matches `REG_BUS_WIDTH`)
- TIMEOUT, 255: max cycles `mem_req_o` may wait for `mem_ack_i` before fault; must be ≥1
- clk_i  in  1  clock; one clock domain only
- rst_i  in  1  reset, asynchronous, active-high
- mem_en_i  in  1  memory op valid from execute
- we_i  in  1  1=store, 0=load
- size_i  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word
- unsign_i  in  1  zero-extend load (LBU/LHU)
- addr_i  in  DATA_W  effective address (execute result)
- wdata_i  in  DATA_W  store data (rs2), right-justified
- reg_waddr_i  in  REG_W  load destination register
- hold_o  out  1  pipeline stall request
- mem_req_o  out  1  bus request, held until ack
- mem_we_o  out  1  bus write
- mem_addr_o  out  DATA_W  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_W  store data replicated into lanes
- mem_ack_i  in  1  bus completion; rdata valid same cycle
- mem_rdata_i  in  DATA_W  bus read word
- reg_we_o  out  1  one-cycle write-back strobe
- reg_waddr_o  out  REG_W  write-back register
- reg_wdata_o  out  DATA_W  aligned, extended load data
- fault_o  out  1  one-cycle fault pulse
- fault_cause_o  out  2  01 misaligned, 10 bus timeout
- fault_addr_o  out  DATA_W  faulting effective address

## Operation
- States: IDLE, REQ, DONE.
- IDLE & mem_en_i:
  - Latch we, size, unsign, addr, wdata, reg_waddr.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0): go to DONE with fault cause 01; no bus access.
  - Otherwise go to REQ and clear the timeout counter.
- REQ:
  - mem_req_o=1; address, we, be and wdata are stable from latched values.
  - mem_ack_i: capture rdata, go to DONE.
  - Counter reaches TIMEOUT without ack: drop req, go to DONE with cause 10.
- DONE, always returns to IDLE:
  - Fault: fault_o=1 for one cycle, reg_we_o=0.
  - Successful load with reg_waddr≠0: reg_we_o=1 for one cycle.
  - Store: no write-back.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 0011 or 1100 selected by addr[1]
  - word: 1111
- Store data: byte replicated ×4, half replicated ×2, word as is.
- Load data:
  - Shift the read word right by 8·addr[1:0].
  - Sign- or zero-extend from bit 7 (byte) or bit 15 (half) according to unsign_i.
- hold_o = (IDLE & mem_en_i) | REQ. It is low in DONE, so execute advances at the end of DONE.
- mem_en_i is ignored in REQ and DONE.
- Timeout counter width is clog2(TIMEOUT+1) and saturates.

## Timing
- Reset values: state IDLE; all outputs 0. Counter and latches are cleared.
- Reset mid-transaction: mem_req_o drops asynchronously, no write-back, no fault.
- Aligned access accepted in cycle N:
  - mem_req_o is high from N+1.
  - Ack in cycle M≥N+1 gives reg_we_o/fault_o in M+1 and IDLE in M+2.
  - Minimum latency is accept to write-back in 2 cycles (ack in N+1).
- Misaligned access: fault in N+1, no mem_req_o.
- Timeout: ack absent for TIMEOUT REQ cycles gives req low and fault pulse the following cycle.
- Ack arriving in the same cycle as the timeout: ack wins, no fault.
- An ack outside REQ is ignored.
- Back-to-back: the next mem_en_i can be accepted in the cycle after DONE.

## Structure
- Shared package/header (`chip_param.v`): size encodings, fault cause codes, state encodings, byte-enable constants.
- One sub-module, core_lsu_align: combinational store-lane replication, byte-enable generation and load extract/extend. It is reused by any future fetch/AMO path.
- The FSM, latches and timeout counter stay in core_lsu.

## Test plan
- LW at 0x1000, rdata 0xDEADBEEF, ack 1 cycle after req: be=1111, addr 0x1000, reg_wdata 0xDEADBEEF, reg_we pulse 2 cycles after accept.
- LB at 0x1003, rdata 0x80FF_FF00 (byte 0x80): unsign=0 gives 0xFFFFFF80; unsign=1 gives 0x00000080.
- SH 0x1234 at 0x2002: mem_be 1100, mem_wdata 0x12341234, mem_we=1, no reg_we.
- LW at 0x2001: fault_o with cause 01 and fault_addr 0x2001 the next cycle, mem_req_o never rises, hold_o released in DONE.
- TIMEOUT=4, no ack: req high exactly 4 cycles, then fault cause 10. Repeat with ack on cycle 4: normal completion, no fault.
- Assert rst_i while in REQ: mem_req_o and hold_o go to 0 immediately. A following LW completes normally.
